// File: rtl/ifu_lsu_bus_arb_pkg.sv
// rtl/ifu_lsu_bus_arb_pkg.sv - shared constants for the IFU/LSU memory bus arbiter
package ifu_lsu_bus_arb_pkg;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;

   localparam int STARVE_W = 4;

   function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/bus_arb_sel.sv
// rtl/bus_arb_sel.sv - combinational requester select for the IFU/LSU bus arbiter
module bus_arb_sel
   import ifu_lsu_bus_arb_pkg::*;
#(
   parameter int LSU_FIRST = 1
) (
   input  logic ifu_v,
   input  logic lsu_v,
   input  logic last_owner,
   input  logic starve_hit,
   output logic sel
);

   always_comb begin
      sel = OWN_IFU;
      if (lsu_v && !ifu_v) begin
         sel = OWN_LSU;
      end else if (lsu_v && ifu_v) begin
         // Tie: fixed LSU priority bounded by the starvation guard, or alternate.
         if (LSU_FIRST != 0) sel = starve_hit ? OWN_IFU : OWN_LSU;
         else                sel = ~last_owner;
      end
   end

endmodule

// File: rtl/ifu_lsu_bus_arb.sv
// rtl/ifu_lsu_bus_arb.sv - shares one memory bus between IFU fetch and LSU data ports
module ifu_lsu_bus_arb
   import ifu_lsu_bus_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int LSU_FIRST  = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ifu_req_valid,
   output logic            ifu_req_ready,
   input  logic [AW-1:0]   ifu_req_addr,
   output logic            ifu_rsp_valid,
   input  logic            ifu_rsp_ready,
   output logic [DW-1:0]   ifu_rsp_rdata,
   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [AW-1:0]   lsu_req_addr,
   input  logic            lsu_req_write,
   input  logic [DW-1:0]   lsu_req_wdata,
   input  logic [DW/8-1:0] lsu_req_wstrb,
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [DW-1:0]   lsu_rsp_rdata,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [AW-1:0]   mem_req_addr,
   output logic            mem_req_write,
   output logic [DW-1:0]   mem_req_wdata,
   output logic [DW/8-1:0] mem_req_wstrb,
   input  logic            mem_rsp_valid,
   output logic            mem_rsp_ready,
   input  logic [DW-1:0]   mem_rsp_rdata,
   output logic            arb_err_unexp
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_MAX[STARVE_W-1:0];

   logic [1:0]          state;
   logic                owner;
   logic                last_owner;
   logic [STARVE_W-1:0] starve_cnt;
   logic                err;
   logic                sel;
   logic                cur;
   logic                starve_hit;
   logic                in_rsp;
   logic                req_hs;
   logic                rsp_hs;

   assign starve_hit = (LSU_FIRST != 0) && (starve_cnt == STARVE_LIM);

   bus_arb_sel #(.LSU_FIRST(LSU_FIRST)) u_sel (
      .ifu_v      (ifu_req_valid),
      .lsu_v      (lsu_req_valid),
      .last_owner (last_owner),
      .starve_hit (starve_hit),
      .sel        (sel)
   );

   assign cur    = (state == ST_IDLE) ? sel : owner;
   assign in_rsp = (state == ST_RSP);

   // Request side is gated by reset so nothing leaks onto the bus while held in reset.
   always_comb begin
      mem_req_valid = 1'b0;
      case (state)
         ST_IDLE: mem_req_valid = ifu_req_valid | lsu_req_valid;
         ST_HOLD: mem_req_valid = (owner == OWN_LSU) ? lsu_req_valid : ifu_req_valid;
         default: mem_req_valid = 1'b0;
      endcase
      mem_req_valid = mem_req_valid & rst;
   end

   assign ifu_req_ready = rst && !in_rsp && (cur == OWN_IFU) && mem_req_ready;
   assign lsu_req_ready = rst && !in_rsp && (cur == OWN_LSU) && mem_req_ready;

   assign mem_req_addr  = (cur == OWN_LSU) ? lsu_req_addr : ifu_req_addr;
   assign mem_req_write = (cur == OWN_LSU) && lsu_req_write;
   assign mem_req_wdata = (cur == OWN_LSU) ? lsu_req_wdata : '0;
   assign mem_req_wstrb = (cur == OWN_LSU) ? lsu_req_wstrb : '0;

   // Outside RSP any response is stray and is drained without reaching either port.
   assign ifu_rsp_valid = in_rsp && (owner == OWN_IFU) && mem_rsp_valid;
   assign lsu_rsp_valid = in_rsp && (owner == OWN_LSU) && mem_rsp_valid;
   assign ifu_rsp_rdata = mem_rsp_rdata;
   assign lsu_rsp_rdata = mem_rsp_rdata;
   assign mem_rsp_ready = in_rsp ? ((owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready) : 1'b1;

   assign req_hs        = mem_req_valid && mem_req_ready;
   assign rsp_hs        = in_rsp && mem_rsp_valid && mem_rsp_ready;
   assign arb_err_unexp = err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_IFU;
         last_owner <= OWN_IFU;
         starve_cnt <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_req_valid) begin
                  owner <= sel;
                  if (mem_req_ready) begin
                     state      <= ST_RSP;
                     last_owner <= sel;
                  end else begin
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!mem_req_valid) begin
                  state <= ST_IDLE;
               end else if (mem_req_ready) begin
                  state      <= ST_RSP;
                  last_owner <= owner;
               end
            end
            ST_RSP: begin
               if (rsp_hs) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (req_hs && cur == OWN_IFU)                  starve_cnt <= '0;
         else if (req_hs && ifu_req_valid)              starve_cnt <= starve_inc(starve_cnt);
         else if (state == ST_IDLE && !ifu_req_valid)   starve_cnt <= '0;

         if (!in_rsp && mem_rsp_valid) err <= 1'b1;
      end
   end

endmodule
